// File: rtl/dbus_responder_pkg.sv
// dbus_responder_pkg: data-bus request/response types shared by the core and its memory responder
package dbus_responder_pkg;
    typedef logic [2:0] msize_t;
    typedef logic [7:0] strobe_t;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        strobe_t     strobe;
        logic [63:0] data;
    } dbus_req_t;
    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
    localparam logic [63:0] DBUS_RESP_BASE_ADDR = 64'h8000_0000;
endpackage

// File: rtl/dbus_responder_ram.sv
// dbus_responder_ram: single-port DEPTH x 64 array, byte write enables, asynchronous read
module dbus_responder_ram #(
    parameter int DEPTH = 4096
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [7:0]               we,
    input  logic [63:0]              wdata,
    output logic [63:0]              rdata
);
    logic [63:0] mem [DEPTH];
    always_ff @(posedge clk)
        for (int i = 0; i < 8; i++)
            if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    assign rdata = mem[idx];
endmodule

// File: rtl/dbus_responder.sv
// dbus_responder: data-bus memory responder with programmable latency over an internal SRAM
// Define DBUS_RESPONDER_RANDOM_STALL_EN to add 0..3 LFSR-driven extra wait cycles per transaction.
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int          DEPTH     = 4096,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = DBUS_RESP_BASE_ADDR
) (
    input  logic                     clk,
    input  logic                     reset,
    input  dbus_req_t                dreq,
    output dbus_resp_t               dresp,
    input  logic                     init_we,
    input  logic [$clog2(DEPTH)-1:0] init_idx,
    input  logic [63:0]              init_data,
    output logic                     busy
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state;
    logic [4:0]  cnt, cnt_init;
    dbus_req_t   req;
    logic [63:0] off, wdata, rdata;
    logic        in_range;
    logic [IW-1:0] idx, ram_idx;
    logic [7:0]  we;
    assign off      = req.addr - BASE_ADDR;
    assign in_range = req.addr >= BASE_ADDR && off < SPAN;
    assign idx      = off[IW+2:3];
    // The single port is shared: backdoor preload owns it in IDLE, the latched request otherwise.
    assign ram_idx  = state == IDLE ? init_idx : idx;
    assign wdata    = state == IDLE ? init_data : req.data;
    assign we       = state == IDLE ? {8{init_we && !dreq.valid}} :
                      (state == RESP && in_range) ? req.strobe : 8'h00;
    assign busy     = state != IDLE;
`ifdef DBUS_RESPONDER_RANDOM_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or negedge reset)
        if (!reset) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign cnt_init = 5'(LATENCY) + {3'b000, lfsr[1:0]};
`else
    assign cnt_init = 5'(LATENCY);
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            req   <= '0;
            dresp <= '0;
        end else begin
            dresp <= '0;
            case (state)
                IDLE: if (dreq.valid) begin
                    req   <= dreq;
                    cnt   <= cnt_init;
                    state <= cnt_init != 5'd0 ? WAIT : RESP;
                end
                WAIT: if (!dreq.valid) state <= IDLE;
                      else begin
                          cnt <= cnt - 5'd1;
                          if (cnt == 5'd1) state <= RESP;
                      end
                RESP: begin
                    dresp.addr_ok <= 1'b1;
                    dresp.data_ok <= 1'b1;
                    dresp.data    <= (req.strobe == 8'h00 && in_range) ? rdata : 64'h0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    dbus_responder_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .idx   (ram_idx),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata)
    );
endmodule
